// File: rtl/score_pair_sequencer_if.sv
// Score write / replay bundle between the output layer,
// the pair sequencer and the argmax comparator.
interface score_pair_sequencer_if #(
    parameter int DATA_W = 16
);
    logic              WR_EN;
    logic [DATA_W-1:0] WR_DATA;
    logic              START;
    logic              CLR_COMP;
    logic              EN_OUT;
    logic              TRIG;
    logic [DATA_W-1:0] OUT1;
    logic [DATA_W-1:0] OUT2;
    logic [7:0]        PAIR_IDX;
    logic              FULL;
    logic              BUSY;
    logic              DONE;
    logic              OVF;

    modport master (
        output WR_EN, WR_DATA, START,
        input  CLR_COMP, EN_OUT, TRIG, OUT1, OUT2,
        input  PAIR_IDX, FULL, BUSY, DONE, OVF
    );

    modport slave (
        input  WR_EN, WR_DATA, START,
        output CLR_COMP, EN_OUT, TRIG, OUT1, OUT2,
        output PAIR_IDX, FULL, BUSY, DONE, OVF
    );
endinterface

// File: rtl/score_pair_sequencer.sv
// Buffers one frame of class scores and replays them as pairs to the argmax stage.
// Optional SEQ_GAP_EN inserts an idle cycle between pairs.
module score_pair_sequencer #(
    parameter int N_CLASSES = 10,
    parameter int DATA_W    = 16
) (
    input  logic                 CLKEXT,
    input  logic                 RST_SEQ,
    score_pair_sequencer_if.slave bus
);
    localparam int         AW     = (N_CLASSES > 2) ? $clog2(N_CLASSES) : 1;
    localparam logic [7:0] N8     = 8'(N_CLASSES);
    localparam logic [7:0] LAST_K = 8'(N_CLASSES / 2 - 1);

`ifdef SEQ_GAP_EN
    typedef enum logic [2:0] {
        IDLE, CLR, ISSUE, GAP, DONE_ST
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE, CLR, ISSUE, DONE_ST
    } state_t;
`endif

    state_t            state;
    logic [DATA_W-1:0] buf_q [N_CLASSES];
    logic [7:0]        cnt;
    logic [7:0]        k;
    logic              clr_q;
    logic              en_q;
    logic              trig_q;
    logic [DATA_W-1:0] out1_q;
    logic [DATA_W-1:0] out2_q;
    logic [7:0]        idx_q;
    logic              full_q;
    logic              busy_q;
    logic              done_q;
    logic              ovf_q;

    // Pair that will be presented on the next TRIG cycle.
    logic [7:0]    k_sel;
    logic [AW-1:0] lo;
    logic [AW-1:0] hi;

    always_comb begin
        k_sel = 8'd0;
        if (state != CLR) begin
`ifdef SEQ_GAP_EN
            k_sel = k;
`else
            k_sel = k + 8'd1;
`endif
        end
        lo = AW'({k_sel, 1'b0});
        hi = lo + AW'(1);
    end

    always_ff @(posedge CLKEXT or posedge RST_SEQ) begin
        if (RST_SEQ) begin
            state  <= IDLE;
            for (int i = 0; i < N_CLASSES; i++)
                buf_q[i] <= '0;
            cnt    <= '0;
            k      <= '0;
            clr_q  <= 1'b0;
            en_q   <= 1'b0;
            trig_q <= 1'b0;
            out1_q <= '0;
            out2_q <= '0;
            idx_q  <= '0;
            full_q <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    // START is judged on the pre-write fill level.
                    if (bus.START && full_q) begin
                        state  <= CLR;
                        clr_q  <= 1'b1;
                        en_q   <= 1'b1;
                        busy_q <= 1'b1;
                    end
                    if (bus.WR_EN) begin
                        if (cnt != N8) begin
                            buf_q[AW'(cnt)] <= bus.WR_DATA;
                            cnt    <= cnt + 8'd1;
                            full_q <= (cnt + 8'd1 == N8);
                        end else begin
                            ovf_q <= 1'b1;
                        end
                    end
                end
                CLR: begin
                    state  <= ISSUE;
                    clr_q  <= 1'b0;
                    k      <= '0;
                    trig_q <= 1'b1;
                    out1_q <= buf_q[lo];
                    out2_q <= buf_q[hi];
                    idx_q  <= '0;
                end
                ISSUE: begin
                    if (k == LAST_K) begin
                        state  <= DONE_ST;
                        trig_q <= 1'b0;
                        done_q <= 1'b1;
                    end else begin
`ifdef SEQ_GAP_EN
                        state  <= GAP;
                        trig_q <= 1'b0;
                        k      <= k + 8'd1;
`else
                        k      <= k + 8'd1;
                        out1_q <= buf_q[lo];
                        out2_q <= buf_q[hi];
                        idx_q  <= k + 8'd1;
`endif
                    end
                end
`ifdef SEQ_GAP_EN
                GAP: begin
                    state  <= ISSUE;
                    trig_q <= 1'b1;
                    out1_q <= buf_q[lo];
                    out2_q <= buf_q[hi];
                    idx_q  <= k;
                end
`endif
                DONE_ST: begin
                    state  <= IDLE;
                    done_q <= 1'b0;
                    en_q   <= 1'b0;
                    busy_q <= 1'b0;
                    cnt    <= '0;
                    full_q <= 1'b0;
                    ovf_q  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.CLR_COMP = clr_q;
    assign bus.EN_OUT   = en_q;
    assign bus.TRIG     = trig_q;
    assign bus.OUT1     = out1_q;
    assign bus.OUT2     = out2_q;
    assign bus.PAIR_IDX = idx_q;
    assign bus.FULL     = full_q;
    assign bus.BUSY     = busy_q;
    assign bus.DONE     = done_q;
    assign bus.OVF      = ovf_q;
endmodule

// File: tb/tb_score_pair_sequencer.sv
// Directed bench for score_pair_sequencer; timing follows the
// SEQ_GAP_EN setting of the build.
module tb_score_pair_sequencer;
    localparam int N    = 10;
    localparam int NP   = N / 2;
    localparam int NCAP = 14;
`ifdef SEQ_GAP_EN
    localparam int STRIDE = 2;
    localparam int DCYC   = N + 1;
`else
    localparam int STRIDE = 1;
    localparam int DCYC   = 2 + NP;
`endif

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    score_pair_sequencer_if #(.DATA_W(16)) bus ();

    score_pair_sequencer #(.N_CLASSES(N), .DATA_W(16)) dut (
        .CLKEXT  (clk),
        .RST_SEQ (rst),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic        o_trig [0:NCAP];
    logic        o_clr  [0:NCAP];
    logic        o_done [0:NCAP];
    logic        o_full [0:NCAP];
    logic        o_busy [0:NCAP];
    logic        o_ovf  [0:NCAP];
    logic [15:0] o1     [0:NCAP];
    logic [15:0] o2     [0:NCAP];
    logic [7:0]  oidx   [0:NCAP];

    task automatic write_frame(input logic [15:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.WR_EN   = 1'b1;
            bus.WR_DATA = base + 16'(i);
        end
        @(negedge clk);
        bus.WR_EN = 1'b0;
    endtask

    // Pulses START, records cycles t+1..t+NCAP, optionally injecting
    // a write of 16'h0003 and/or a second START mid-replay.
    task automatic capture(input int wr_at, input int st_at);
        @(negedge clk);
        bus.START = 1'b1;
        for (int c = 1; c <= NCAP; c++) begin
            @(negedge clk);
            bus.START = 1'b0;
            bus.WR_EN = 1'b0;
            o_trig[c] = bus.TRIG;
            o_clr[c]  = bus.CLR_COMP;
            o_done[c] = bus.DONE;
            o_full[c] = bus.FULL;
            o_busy[c] = bus.BUSY;
            o_ovf[c]  = bus.OVF;
            o1[c]     = bus.OUT1;
            o2[c]     = bus.OUT2;
            oidx[c]   = bus.PAIR_IDX;
            if (c == wr_at) begin
                bus.WR_EN   = 1'b1;
                bus.WR_DATA = 16'h0003;
            end
            if (c == st_at) bus.START = 1'b1;
        end
        bus.START = 1'b0;
        bus.WR_EN = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.WR_EN = 1'b0;
        bus.WR_DATA = '0;
        bus.START = 1'b0;
        #12;
        checks++;
        if ({bus.CLR_COMP, bus.EN_OUT, bus.TRIG, bus.BUSY, bus.DONE,
             bus.OVF, bus.FULL, bus.OUT1, bus.OUT2, bus.PAIR_IDX} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got nonzero outputs, want all 0");
        end
        @(negedge clk);
        rst = 1'b0;
        bus.START = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if ({bus.CLR_COMP, bus.EN_OUT, bus.TRIG, bus.BUSY, bus.DONE} !== 5'b0) begin
                failures++;
                $display("FAIL idle_start_ignored: cyc %0d got %b want 00000", c,
                         {bus.CLR_COMP, bus.EN_OUT, bus.TRIG, bus.BUSY, bus.DONE});
            end
        end
        bus.START = 1'b0;
    endtask

    task automatic test_full_frame();
        logic et;
        int   kk;
        write_frame(16'hFFF1, N);
        checks++;
        if (bus.FULL !== 1'b1) begin
            failures++;
            $display("FAIL frame_full: got %b want 1", bus.FULL);
        end
        capture(0, 0);
        for (int c = 1; c <= NCAP; c++) begin
            et = (c >= 2) && (c < 2 + STRIDE * NP) && ((c - 2) % STRIDE == 0);
            checks++;
            if (o_trig[c] !== et || o_clr[c] !== (c == 1) || o_done[c] !== (c == DCYC)) begin
                failures++;
                $display("FAIL frame_ctl: cyc %0d trig/clr/done got %b%b%b want %b%b%b", c,
                         o_trig[c], o_clr[c], o_done[c], et, c == 1, c == DCYC);
            end
            if (et) begin
                kk = (c - 2) / STRIDE;
                checks++;
                if (o1[c] !== 16'hFFF1 + 16'(2 * kk) || o2[c] !== 16'hFFF2 + 16'(2 * kk)
                    || oidx[c] !== 8'(kk)) begin
                    failures++;
                    $display("FAIL frame_pair: cyc %0d got %h %h %0d want %h %h %0d", c,
                             o1[c], o2[c], oidx[c], 16'hFFF1 + 16'(2 * kk),
                             16'hFFF2 + 16'(2 * kk), kk);
                end
            end
        end
        checks++;
        if (o_full[DCYC + 1] !== 1'b0 || o_busy[DCYC + 1] !== 1'b0 || o_busy[DCYC] !== 1'b1) begin
            failures++;
            $display("FAIL frame_end: full %b busy %b busy_at_done %b want 0 0 1",
                     o_full[DCYC + 1], o_busy[DCYC + 1], o_busy[DCYC]);
        end
    endtask

    task automatic test_overflow();
        write_frame(16'h0A00, N);
        write_frame(16'h1234, 1);
        checks++;
        if (bus.OVF !== 1'b1 || bus.FULL !== 1'b1) begin
            failures++;
            $display("FAIL ovf_set: ovf %b full %b want 1 1", bus.OVF, bus.FULL);
        end
        capture(0, 0);
        checks++;
        if (o1[2] !== 16'h0A00 || o2[2 + STRIDE * (NP - 1)] !== 16'h0A09) begin
            failures++;
            $display("FAIL ovf_buf: first %h last %h want 0a00 0a09",
                     o1[2], o2[2 + STRIDE * (NP - 1)]);
        end
        checks++;
        if (o_ovf[DCYC] !== 1'b1 || o_ovf[DCYC + 1] !== 1'b0) begin
            failures++;
            $display("FAIL ovf_clear: at done %b after %b want 1 0",
                     o_ovf[DCYC], o_ovf[DCYC + 1]);
        end
    endtask

    task automatic test_ignored();
        int bad;
        write_frame(16'h0B00, N);
        capture(3, 4);
        bad = 0;
        for (int kk = 0; kk < NP; kk++) begin
            if (o_trig[2 + STRIDE * kk] !== 1'b1
                || o1[2 + STRIDE * kk] !== 16'h0B00 + 16'(2 * kk)
                || o2[2 + STRIDE * kk] !== 16'h0B01 + 16'(2 * kk))
                bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL ign_pairs: %0d bad pairs want 0", bad);
        end
        checks++;
        if (o_done[DCYC] !== 1'b1 || o_clr[DCYC + 1] !== 1'b0 || o_ovf[DCYC - 1] !== 1'b0) begin
            failures++;
            $display("FAIL ign_timing: done %b clr_after %b ovf %b want 1 0 0",
                     o_done[DCYC], o_clr[DCYC + 1], o_ovf[DCYC - 1]);
        end
        write_frame(16'h0C00, N - 1);
        checks++;
        if (bus.FULL !== 1'b0) begin
            failures++;
            $display("FAIL ign_cnt: full after 9 writes %b want 0", bus.FULL);
        end
    endtask

    task automatic test_simultaneous();
        @(negedge clk);
        bus.WR_EN   = 1'b1;
        bus.WR_DATA = 16'h0C09;
        bus.START   = 1'b1;
        @(negedge clk);
        bus.WR_EN = 1'b0;
        bus.START = 1'b0;
        checks++;
        if (bus.FULL !== 1'b1 || bus.CLR_COMP !== 1'b0 || bus.BUSY !== 1'b0) begin
            failures++;
            $display("FAIL simul: full %b clr %b busy %b want 1 0 0",
                     bus.FULL, bus.CLR_COMP, bus.BUSY);
        end
        @(negedge clk);
        checks++;
        if (bus.CLR_COMP !== 1'b0) begin
            failures++;
            $display("FAIL simul_noclr: clr %b want 0", bus.CLR_COMP);
        end
        capture(0, 0);
        checks++;
        if (o_clr[1] !== 1'b1 || o1[2] !== 16'h0C00 || o2[2 + STRIDE * (NP - 1)] !== 16'h0C09) begin
            failures++;
            $display("FAIL simul_replay: clr %b first %h last %h want 1 0c00 0c09",
                     o_clr[1], o1[2], o2[2 + STRIDE * (NP - 1)]);
        end
    endtask

    task automatic test_reset_mid();
        int bad;
        write_frame(16'h0E00, N);
        @(negedge clk);
        bus.START = 1'b1;
        for (int c = 1; c <= 2 + 2 * STRIDE; c++) begin
            @(negedge clk);
            bus.START = 1'b0;
        end
        checks++;
        if (bus.TRIG !== 1'b1 || bus.PAIR_IDX !== 8'd2 || bus.OUT1 !== 16'h0E04) begin
            failures++;
            $display("FAIL mid_pair2: trig %b idx %0d out1 %h want 1 2 0e04",
                     bus.TRIG, bus.PAIR_IDX, bus.OUT1);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({bus.TRIG, bus.DONE, bus.BUSY, bus.EN_OUT, bus.FULL} !== 5'b0
            || bus.OUT1 !== 16'h0 || bus.PAIR_IDX !== 8'd0) begin
            failures++;
            $display("FAIL mid_reset: trig %b busy %b out1 %h idx %0d want 0 0 0 0",
                     bus.TRIG, bus.BUSY, bus.OUT1, bus.PAIR_IDX);
        end
        @(negedge clk);
        rst = 1'b0;
        bad = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (bus.TRIG !== 1'b0 || bus.DONE !== 1'b0 || bus.FULL !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL mid_quiet: %0d active cycles want 0", bad);
        end
        write_frame(16'h0001, N);
        capture(0, 0);
        bad = 0;
        for (int kk = 0; kk < NP; kk++) begin
            if (o1[2 + STRIDE * kk] !== 16'h0001 + 16'(2 * kk)
                || o2[2 + STRIDE * kk] !== 16'h0002 + 16'(2 * kk)
                || oidx[2 + STRIDE * kk] !== 8'(kk))
                bad++;
        end
        checks++;
        if (bad != 0 || o_done[DCYC] !== 1'b1) begin
            failures++;
            $display("FAIL mid_refill: %0d bad pairs done %b want 0 1", bad, o_done[DCYC]);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_full_frame();
        test_overflow();
        test_ignored();
        test_simultaneous();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
